// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared phase encoding and phase-length lookup for the raster timing generator.
package video_timing_pkg;
  localparam int POS_W = 11;
  typedef enum logic [1:0] {PH_VISIBLE, PH_FRONT, PH_SYNC, PH_BACK} video_phase_t;
  function automatic int phase_len(video_phase_t p, int v, int f, int s, int b);
    return p == PH_VISIBLE ? v : p == PH_FRONT ? f : p == PH_SYNC ? s : b;
  endfunction
endpackage

// File: rtl/video_phase_counter.sv
// video_phase_counter: enable-stepped position counter with visible/front/sync/back phase tracking.
module video_phase_counter
  import video_timing_pkg::*;
#(
  parameter int VISIBLE = 640,
  parameter int FRONT   = 16,
  parameter int SYNC    = 96,
  parameter int BACK    = 48
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_enable,
  output logic [POS_W-1:0] o_count,
  output video_phase_t     o_phase,
  output logic             o_wrap
);
  localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;
  video_phase_t phase_n;
  logic [POS_W-1:0] pcnt;
  logic last;
  // pcnt counts within the current phase so each phase ends on its own length
  assign last = pcnt == POS_W'(phase_len(o_phase, VISIBLE, FRONT, SYNC, BACK) - 1);
  assign o_wrap = i_enable && o_count == POS_W'(TOTAL - 1);
  always_comb phase_n = (i_enable && last) ? video_phase_t'(o_phase + 2'd1) : o_phase;
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_count <= '0;
      pcnt    <= '0;
      o_phase <= PH_VISIBLE;
    end else begin
      o_phase <= phase_n;
      if (i_enable) begin
        o_count <= o_wrap ? '0 : o_count + 1'b1;
        pcnt    <= last ? '0 : pcnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/video_timing_generator.sv
// video_timing_generator: raster position/flag source with latency-matched sync, DE and pixel output.
module video_timing_generator
  import video_timing_pkg::*;
#(
  parameter int H_VISIBLE    = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_VISIBLE    = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter int SYNC_ACTIVE  = 0,
  parameter int CLOCK_DIV    = 1,
  parameter int DATA_LATENCY = 3
) (
  input  logic             i_clock,
  input  logic             i_reset,
  output logic             o_video_hblank,
  output logic             o_video_vblank,
  output logic [POS_W-1:0] o_video_pos_x,
  output logic [POS_W-1:0] o_video_pos_y,
  input  logic [31:0]      i_video_rdata,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_data_enable,
  output logic [23:0]      o_rgb,
  output logic             o_frame_irq
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW = CLOCK_DIV > 1 ? $clog2(CLOCK_DIV) : 1;
  localparam logic SA = SYNC_ACTIVE != 0;
  localparam logic [2:0] IDLE = {~SA, ~SA, 1'b0};
  if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_size_check
    $error("video_timing_generator: H_TOTAL/V_TOTAL must not exceed 2048");
  end
  logic [DW-1:0] div;
  logic tick, h_wrap, unused_v_wrap, unused_rdata;
  logic [POS_W-1:0] h_count, v_count;
  video_phase_t h_phase, v_phase;
  logic [2:0] raw;
  logic [DATA_LATENCY:0][2:0] pipe;
  assign tick = div == DW'(CLOCK_DIV - 1);
  video_phase_counter #(.VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)) u_h (
    .i_clock(i_clock), .i_reset(i_reset), .i_enable(tick),
    .o_count(h_count), .o_phase(h_phase), .o_wrap(h_wrap)
  );
  video_phase_counter #(.VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)) u_v (
    .i_clock(i_clock), .i_reset(i_reset), .i_enable(h_wrap),
    .o_count(v_count), .o_phase(v_phase), .o_wrap(unused_v_wrap)
  );
  assign raw = {h_phase == PH_SYNC ? SA : ~SA, v_phase == PH_SYNC ? SA : ~SA,
                h_phase == PH_VISIBLE && v_phase == PH_VISIBLE};
  // pipe[0] is registered alongside pos; pipe[DATA_LATENCY] lines up with the returning pixel
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      div            <= '0;
      o_video_pos_x  <= '0;
      o_video_pos_y  <= '0;
      o_video_hblank <= 1'b0;
      o_video_vblank <= 1'b0;
      o_frame_irq    <= 1'b0;
      pipe           <= {(DATA_LATENCY + 1){IDLE}};
    end else begin
      div            <= tick ? '0 : div + 1'b1;
      o_video_pos_x  <= h_count;
      o_video_pos_y  <= v_count;
      o_video_hblank <= h_phase == PH_VISIBLE;
      o_video_vblank <= v_phase == PH_VISIBLE;
      o_frame_irq    <= v_count == POS_W'(V_VISIBLE) && o_video_pos_y == POS_W'(V_VISIBLE - 1);
      pipe[0]        <= raw;
      for (int i = 1; i <= DATA_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign {o_hsync, o_vsync, o_data_enable} = pipe[DATA_LATENCY];
  assign o_rgb = o_data_enable ? i_video_rdata[23:0] : '0;
  assign unused_rdata = ^i_video_rdata[31:24];
endmodule

// File: tb/tb_video_timing_generator.sv
// tb_video_timing_generator: checks four timing configurations against an arithmetic raster model.
module tb_video_timing_generator;
  typedef struct packed {int hv, hf, hs, hb, vv, vf, vs, vb, sa, div, lat;} cfg_t;
  typedef struct packed {logic [10:0] x, y; logic hb, vb, hs, vs, de, irq; logic [23:0] rgb;} obs_t;
  localparam cfg_t CA = '{8, 2, 2, 2, 4, 1, 1, 1, 0, 1, 0};
  localparam cfg_t CB = '{8, 2, 2, 2, 4, 1, 1, 1, 1, 3, 3};
  localparam cfg_t CC = '{640, 16, 96, 48, 6, 1, 2, 1, 1, 1, 0};
  localparam cfg_t CD = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 1, 3};
  logic clk = 1'b0, rst = 1'b1, rst_s = 1'b1, started = 1'b0;
  logic [31:0] rdata_v = 32'h0;
  logic [31:0] rdata_b = 32'hFF123456;
  int checks = 0, errors = 0, t = -1, a_last = -1, c_irqs = 0;
  logic [10:0] a_prev_y = '0;
  logic [10:0] a_x, a_y, b_x, b_y, c_x, c_y, d_x, d_y;
  logic a_hb, a_vb, a_hs, a_vs, a_de, a_irq, b_hb, b_vb, b_hs, b_vs, b_de, b_irq;
  logic c_hb, c_vb, c_hs, c_vs, c_de, c_irq, d_hb, d_vb, d_hs, d_vs, d_de, d_irq;
  logic [23:0] a_rgb, b_rgb, c_rgb, d_rgb;
  always #5 clk = ~clk;
  video_timing_generator #(.H_VISIBLE(CA.hv), .H_FRONT(CA.hf), .H_SYNC(CA.hs), .H_BACK(CA.hb),
    .V_VISIBLE(CA.vv), .V_FRONT(CA.vf), .V_SYNC(CA.vs), .V_BACK(CA.vb), .SYNC_ACTIVE(CA.sa),
    .CLOCK_DIV(CA.div), .DATA_LATENCY(CA.lat)) dut_a (
    .i_clock(clk), .i_reset(rst), .o_video_hblank(a_hb), .o_video_vblank(a_vb),
    .o_video_pos_x(a_x), .o_video_pos_y(a_y), .i_video_rdata(rdata_v), .o_hsync(a_hs),
    .o_vsync(a_vs), .o_data_enable(a_de), .o_rgb(a_rgb), .o_frame_irq(a_irq));
  video_timing_generator #(.H_VISIBLE(CB.hv), .H_FRONT(CB.hf), .H_SYNC(CB.hs), .H_BACK(CB.hb),
    .V_VISIBLE(CB.vv), .V_FRONT(CB.vf), .V_SYNC(CB.vs), .V_BACK(CB.vb), .SYNC_ACTIVE(CB.sa),
    .CLOCK_DIV(CB.div), .DATA_LATENCY(CB.lat)) dut_b (
    .i_clock(clk), .i_reset(rst), .o_video_hblank(b_hb), .o_video_vblank(b_vb),
    .o_video_pos_x(b_x), .o_video_pos_y(b_y), .i_video_rdata(rdata_b), .o_hsync(b_hs),
    .o_vsync(b_vs), .o_data_enable(b_de), .o_rgb(b_rgb), .o_frame_irq(b_irq));
  video_timing_generator #(.H_VISIBLE(CC.hv), .H_FRONT(CC.hf), .H_SYNC(CC.hs), .H_BACK(CC.hb),
    .V_VISIBLE(CC.vv), .V_FRONT(CC.vf), .V_SYNC(CC.vs), .V_BACK(CC.vb), .SYNC_ACTIVE(CC.sa),
    .CLOCK_DIV(CC.div), .DATA_LATENCY(CC.lat)) dut_c (
    .i_clock(clk), .i_reset(rst), .o_video_hblank(c_hb), .o_video_vblank(c_vb),
    .o_video_pos_x(c_x), .o_video_pos_y(c_y), .i_video_rdata(rdata_v), .o_hsync(c_hs),
    .o_vsync(c_vs), .o_data_enable(c_de), .o_rgb(c_rgb), .o_frame_irq(c_irq));
  video_timing_generator dut_d (
    .i_clock(clk), .i_reset(rst), .o_video_hblank(d_hb), .o_video_vblank(d_vb),
    .o_video_pos_x(d_x), .o_video_pos_y(d_y), .i_video_rdata(rdata_v), .o_hsync(d_hs),
    .o_vsync(d_vs), .o_data_enable(d_de), .o_rgb(d_rgb), .o_frame_irq(d_irq));
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got %h want %h", name, t, act, exp);
    end
  endtask
  // t counts clocks since the first valid (0,0) output; t=-1 is a reset cycle
  function automatic obs_t model(cfg_t c, int tt, logic [31:0] rd);
    obs_t o;
    int ht, vt, p, x, y, pd, xd, yd;
    ht = c.hv + c.hf + c.hs + c.hb;
    vt = c.vv + c.vf + c.vs + c.vb;
    o = '0;
    o.hs = c.sa == 0;
    o.vs = c.sa == 0;
    if (tt < 0) return o;
    p = tt / c.div;
    x = p % ht;
    y = (p / ht) % vt;
    o.x = 11'(x);
    o.y = 11'(y);
    o.hb = x < c.hv;
    o.vb = y < c.vv;
    o.irq = (tt % c.div == 0) && x == 0 && y == c.vv;
    if (tt - c.lat >= 0) begin
      pd = (tt - c.lat) / c.div;
      xd = pd % ht;
      yd = (pd / ht) % vt;
      o.hs = (xd >= c.hv + c.hf && xd < c.hv + c.hf + c.hs) ? (c.sa != 0) : (c.sa == 0);
      o.vs = (yd >= c.vv + c.vf && yd < c.vv + c.vf + c.vs) ? (c.sa != 0) : (c.sa == 0);
      o.de = xd < c.hv && yd < c.vv;
    end
    o.rgb = o.de ? rd[23:0] : 24'h0;
    return o;
  endfunction
  always @(posedge clk) begin
    rst_s <= rst;
    started <= 1'b1;
  end
  always @(negedge clk) if (started) begin
    t = rst_s ? -1 : t + 1;
    chk("a_model", {a_x, a_y, a_hb, a_vb, a_hs, a_vs, a_de, a_irq, a_rgb}, model(CA, t, rdata_v));
    chk("b_model", {b_x, b_y, b_hb, b_vb, b_hs, b_vs, b_de, b_irq, b_rgb}, model(CB, t, rdata_b));
    chk("c_model", {c_x, c_y, c_hb, c_vb, c_hs, c_vs, c_de, c_irq, c_rgb}, model(CC, t, rdata_v));
    chk("d_model", {d_x, d_y, d_hb, d_vb, d_hs, d_vs, d_de, d_irq, d_rgb}, model(CD, t, rdata_v));
    if (t == -1) begin
      chk("a_reset", {a_x, a_y, a_hb, a_vb, a_hs, a_vs, a_de, a_irq, a_rgb}, {22'd0, 6'b001100, 24'd0});
      chk("b_reset_sync", {b_hs, b_vs, b_de, b_rgb}, {3'b000, 24'd0});
    end
    if (t == 0) chk("a_first", {a_x, a_y, a_hb, a_vb}, {22'd0, 2'b11});
    if (t == 7) chk("a_hb7", a_hb, 1);
    if (t == 8) chk("a_hb8", a_hb, 0);
    if (t == 9) chk("a_hs9", a_hs, 1);
    if (t == 10) chk("a_hs10", a_hs, 0);
    if (t == 11) chk("a_hs11", a_hs, 0);
    if (t == 12) chk("a_hs12", a_hs, 1);
    if (t == 2) chk("b_de2", {b_de, b_rgb}, {1'b0, 24'h0});
    if (t == 3) chk("b_de3", {b_de, b_rgb}, {1'b1, 24'h123456});
    if (t == 5) chk("b_x5", b_x, 1);
    if (t == 6) chk("b_x6", b_x, 2);
    if (t == 41) chk("b_x41", {b_x, b_y}, {11'd13, 11'd0});
    if (t == 42) chk("b_x42", {b_x, b_y}, {11'd0, 11'd1});
    if (t == 655) chk("c_hs655", c_hs, 0);
    if (t == 656) chk("c_hs656", c_hs, 1);
    if (t == 658) chk("d_hs658", d_hs, 1);
    if (t == 659) chk("d_hs659", d_hs, 0);
    if (t == 799) chk("d_x799", {d_x, d_y}, {11'd799, 11'd0});
    if (t == 800) chk("d_x800", {d_x, d_y}, {11'd0, 11'd1});
    if (rst_s) begin
      a_last = -1;
      c_irqs = 0;
    end
    if (a_irq) begin
      chk("a_irq_y", a_y, 4);
      chk("a_irq_prev_y", a_prev_y, 3);
      if (a_last >= 0) chk("a_irq_period", t - a_last, 98);
      a_last = t;
    end
    a_prev_y = a_y;
    if (c_irq) c_irqs++;
  end
  initial begin
    forever begin
      @(posedge clk);
      #1 rdata_v = $urandom;
    end
  end
  initial begin
    logic found;
    found = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      #1 found = a_x == 11'd5 && a_y == 11'd2;
    end
    chk("a_wait_5_2", found, 1);
    rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (17000) @(posedge clk);
    #2 chk("c_irq_count", c_irqs, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
